// File: rtl/alu_operand_entry_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_operand_entry_if
//  Description : Request/result bus between the operand entry front end and
//                the ALU. The entry block drives the operands, opcode and the
//                request; the ALU answers with ack and the result word.
//  Ports       : a_out/b_out (WORD_W) operands, op_out (4) opcode,
//                req request valid, ack request accepted,
//                result_in (WORD_W) ALU result, valid with req&&ack.
//  Revision    : 1.0  initial release
// ============================================================================
interface alu_operand_entry_if #(
    parameter int WORD_W = 32
);
    logic [WORD_W-1:0] a_out;
    logic [WORD_W-1:0] b_out;
    logic [3:0]        op_out;
    logic              req;
    logic              ack;
    logic [WORD_W-1:0] result_in;

    // Operand entry side
    modport master (
        output a_out,
        output b_out,
        output op_out,
        output req,
        input  ack,
        input  result_in
    );

    // ALU side
    modport slave (
        input  a_out,
        input  b_out,
        input  op_out,
        input  req,
        output ack,
        output result_in
    );
endinterface
`default_nettype wire

// File: rtl/alu_operand_entry.sv
`default_nettype none
// ============================================================================
//  Module      : alu_operand_entry
//  Description : Board input front end for the ALU harness. Synchronizes and
//                debounces the pushbuttons, turns key presses into commit /
//                clear events and assembles two WORD_W operands from 16-bit
//                switch chunks plus a 4-bit opcode, then issues one req/ack
//                transaction and holds the returned result.
//  Ports       : CLOCK_50   system clock
//                nRST       synchronous active-low reset
//                KEY[3:0]   raw active-low pushbuttons (KEY0 commit, KEY1 clear)
//                SW[17:0]   raw switches, SW[15:0] chunk, SW[3:0] opcode
//                bus        request/result bus (master side)
//                result_out captured ALU result
//                state_out  FSM state for the LEDs
//                done       high while the result is being shown
//  Revision    : 1.0  initial release
// ============================================================================
module alu_operand_entry #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int WORD_W          = 32
) (
    input  logic                CLOCK_50,
    input  logic                nRST,
    input  logic [3:0]          KEY,
    input  logic [17:0]         SW,
    alu_operand_entry_if.master bus,
    output logic [WORD_W-1:0]   result_out,
    output logic [2:0]          state_out,
    output logic                done
);

    localparam int CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int CHUNK_W = WORD_W / 2;
    localparam logic [CNT_W-1:0] c_CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [2:0] c_ENTER_A_LO = 3'd0;
    localparam logic [2:0] c_ENTER_A_HI = 3'd1;
    localparam logic [2:0] c_ENTER_B_LO = 3'd2;
    localparam logic [2:0] c_ENTER_B_HI = 3'd3;
    localparam logic [2:0] c_ENTER_OP   = 3'd4;
    localparam logic [2:0] c_ISSUE      = 3'd5;
    localparam logic [2:0] c_DONE       = 3'd6;

    // ------------------------------------------------------------------
    // Input synchronizers. Key flops reset to the released level so that a
    // reset never looks like a key transition to the debouncers.
    // ------------------------------------------------------------------
    logic [3:0]  r_key_meta;
    logic [3:0]  r_key_sync;
    logic [17:0] r_sw_meta;
    logic [17:0] r_sw_sync;

    always_ff @(posedge CLOCK_50) begin
        if (!nRST) begin
            r_key_meta <= '1;
            r_key_sync <= '1;
            r_sw_meta  <= '0;
            r_sw_sync  <= '0;
        end else begin
            r_key_meta <= KEY;
            r_key_sync <= r_key_meta;
            r_sw_meta  <= SW;
            r_sw_sync  <= r_sw_meta;
        end
    end

    // ------------------------------------------------------------------
    // Per-key debounce and press detection
    // ------------------------------------------------------------------
    logic [3:0] w_press;

    for (genvar gi = 0; gi < 4; gi++) begin : g_key
        logic [CNT_W-1:0] r_cnt;
        logic             r_db;
        logic             r_db_d;

        // The level is accepted only after DEBOUNCE_CYCLES consecutive
        // cycles of disagreement; any return to the accepted level restarts.
        always_ff @(posedge CLOCK_50) begin
            if (!nRST) begin
                r_cnt  <= '0;
                r_db   <= 1'b1;
                r_db_d <= 1'b1;
            end else begin
                r_db_d <= r_db;
                if (r_key_sync[gi] != r_db) begin
                    if (r_cnt == c_CNT_MAX) begin
                        r_db  <= r_key_sync[gi];
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end else begin
                    r_cnt <= '0;
                end
            end
        end

        // Active-low keys: a press is the debounced 1->0 edge
        assign w_press[gi] = r_db_d & ~r_db;
    end

    logic w_commit;
    logic w_clear;
    assign w_commit = w_press[0];
    assign w_clear  = w_press[1];

    // KEY2/KEY3 and the upper switches carry no function here
    logic w_unused;
    assign w_unused = &{1'b0, w_press[3:2], r_sw_sync[17:16]};

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    logic [2:0]        r_state;
    logic [2:0]        w_state_nxt;
    logic              r_req;
    logic [WORD_W-1:0] r_a;
    logic [WORD_W-1:0] r_b;
    logic [3:0]        r_op;
    logic [WORD_W-1:0] r_result;

    logic w_load;
    logic w_clr;
    logic w_cap;
    logic w_ld_a_lo;
    logic w_ld_a_hi;
    logic w_ld_b_lo;
    logic w_ld_b_hi;
    logic w_ld_op;

    always_ff @(posedge CLOCK_50) begin
        if (!nRST) begin
            r_state <= c_ENTER_A_LO;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (r_state > c_DONE) begin
            w_state_nxt = c_ENTER_A_LO;
        end else if (r_state == c_ISSUE) begin
            if (w_cap) begin
                w_state_nxt = c_DONE;
            end
        end else if (w_clear) begin
            w_state_nxt = c_ENTER_A_LO;
        end else if (w_commit) begin
            case (r_state)
                c_ENTER_A_LO: w_state_nxt = c_ENTER_A_HI;
                c_ENTER_A_HI: w_state_nxt = c_ENTER_B_LO;
                c_ENTER_B_LO: w_state_nxt = c_ENTER_B_HI;
                c_ENTER_B_HI: w_state_nxt = c_ENTER_OP;
                c_ENTER_OP:   w_state_nxt = c_ISSUE;
                default:      w_state_nxt = c_ENTER_A_LO;
            endcase
        end
    end

    // Clear outranks commit; both are ignored while a request is pending
    always_comb begin
        w_clr     = (r_state != c_ISSUE) && w_clear;
        w_load    = (r_state != c_ISSUE) && !w_clear && w_commit;
        w_ld_a_lo = w_load && (r_state == c_ENTER_A_LO);
        w_ld_a_hi = w_load && (r_state == c_ENTER_A_HI);
        w_ld_b_lo = w_load && (r_state == c_ENTER_B_LO);
        w_ld_b_hi = w_load && (r_state == c_ENTER_B_HI);
        w_ld_op   = w_load && (r_state == c_ENTER_OP);
        w_cap     = (r_state == c_ISSUE) && r_req && bus.ack;
        done      = (r_state == c_DONE);
        state_out = r_state;
    end

    // ------------------------------------------------------------------
    // Operand / result registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLOCK_50) begin
        if (!nRST) begin
            r_req    <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= '0;
            r_result <= '0;
        end else begin
            // Registered so req rises together with the ISSUE state
            r_req <= (w_state_nxt == c_ISSUE);
            if (w_clr) begin
                r_a  <= '0;
                r_b  <= '0;
                r_op <= '0;
            end else begin
                if (w_ld_a_lo) r_a[CHUNK_W-1:0]      <= r_sw_sync[CHUNK_W-1:0];
                if (w_ld_a_hi) r_a[WORD_W-1:CHUNK_W] <= r_sw_sync[CHUNK_W-1:0];
                if (w_ld_b_lo) r_b[CHUNK_W-1:0]      <= r_sw_sync[CHUNK_W-1:0];
                if (w_ld_b_hi) r_b[WORD_W-1:CHUNK_W] <= r_sw_sync[CHUNK_W-1:0];
                if (w_ld_op)   r_op                  <= r_sw_sync[3:0];
            end
            if (w_cap) begin
                r_result <= bus.result_in;
            end
        end
    end

    assign bus.a_out  = r_a;
    assign bus.b_out  = r_b;
    assign bus.op_out = r_op;
    assign bus.req    = r_req;
    assign result_out = r_result;

endmodule
`default_nettype wire
